// File: rtl/bram_line_loader_if.sv
// Handshake and BRAM port-A bundle for the line loader.
// The job/pipe side drives the master modport. The loader uses the slave modport.
interface bram_line_loader_if #(
    parameter int BURST_LEN = 8,
    parameter int ADDR_W    = 10
);
    logic                    start;
    logic [ADDR_W-1:0]       base_addr;
    logic [ADDR_W:0]         line_total;
    logic                    flush;
    logic                    in_valid;
    logic [31:0]             in_data;
    logic                    ram_wr_en;
    logic [ADDR_W-1:0]       ram_addr;
    logic [16*BURST_LEN-1:0] ram_data;
    logic                    busy;
    logic                    done;
    logic [ADDR_W:0]         lines_written;
    logic                    drop_err;

    modport master (
        output start, base_addr, line_total, flush, in_valid, in_data,
        input  ram_wr_en, ram_addr, ram_data, busy, done,
        input  lines_written, drop_err
    );

    modport slave (
        input  start, base_addr, line_total, flush, in_valid, in_data,
        output ram_wr_en, ram_addr, ram_data, busy, done,
        output lines_written, drop_err
    );
endinterface

// File: rtl/bram_line_loader.sv
// Packs 16-bit pipe words into BURST_LEN-lane BRAM lines and writes them
// to consecutive addresses, with zero-padded flush of a partial line.
module bram_line_loader #(
    parameter int BURST_LEN = 8,
    parameter int ADDR_W    = 10
) (
    input logic              clk,
    input logic              rst,
    bram_line_loader_if.slave bus
);
    localparam int DW = 16 * BURST_LEN;
    localparam int CW = $clog2(BURST_LEN + 1);
    localparam int LW = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DW-1:0]     data_q, data_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [LW-1:0]     lines_q, lines_d;
    logic [LW-1:0]     total_q, total_d;
    logic              wr_q, wr_d;
    logic              drop_q, drop_d;
    logic              full;
    logic              unused_hi;

    assign unused_hi = ^bus.in_data[31:16];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            lines_q <= '0;
            total_q <= '0;
            wr_q    <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            lines_q <= lines_d;
            total_q <= total_d;
            wr_q    <= wr_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        lines_d = lines_q;
        total_d = total_q;
        wr_d    = 1'b0;
        drop_d  = drop_q;
        full    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    drop_d  = 1'b0;
                    lines_d = '0;
                    total_d = bus.line_total;
                    if (bus.line_total == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOAD;
                        addr_d  = bus.base_addr;
                        cnt_d   = '0;
                        data_d  = '0;
                    end
                end else if (bus.in_valid) begin
                    drop_d = 1'b1;
                end
            end
            S_LOAD: begin
                if (wr_q) begin
                    addr_d  = addr_q + 1'b1;
                    lines_d = lines_q + 1'b1;
                end
                // The final line's write cycle has no line left to receive a word
                if (wr_q && (lines_q + 1'b1) == total_q) begin
                    state_d = S_DONE;
                    if (bus.in_valid) drop_d = 1'b1;
                end else begin
                    if (bus.in_valid) begin
                        data_d = {bus.in_data[15:0], data_q[DW-1:16]};
                        if (cnt_q == CW'(BURST_LEN - 1)) begin
                            cnt_d = '0;
                            wr_d  = 1'b1;
                            full  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    // A just-completed line still needs its write cycle in FLUSH
                    if (bus.flush) begin
                        if (cnt_d == '0 && !full) state_d = S_DONE;
                        else                      state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (bus.in_valid) drop_d = 1'b1;
                if (wr_q) begin
                    addr_d  = addr_q + 1'b1;
                    lines_d = lines_q + 1'b1;
                    state_d = S_DONE;
                end else begin
                    data_d = {16'h0000, data_q[DW-1:16]};
                    if (cnt_q == CW'(BURST_LEN - 1)) begin
                        cnt_d = '0;
                        wr_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (bus.in_valid) drop_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.ram_wr_en     = wr_q;
    assign bus.ram_addr      = addr_q;
    assign bus.ram_data      = data_q;
    assign bus.busy          = (state_q == S_LOAD) || (state_q == S_FLUSH);
    assign bus.done          = (state_q == S_DONE);
    assign bus.lines_written = lines_q;
    assign bus.drop_err      = drop_q;
endmodule
